uart_msg_framer: RTL

//  Sequences the UART receive byte stream into fixed-length price messages for the trading core.

---
 rtl/uart_msg_framer_pkg.sv | 21 ++
 rtl/uart_msg_framer_gap_timer.sv | 34 +++
 rtl/uart_msg_framer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/uart_msg_framer_pkg.sv
// Shared definitions for the UART price-message framer: state encoding,
// default framing constants and the running checksum helper.
package uart_msg_framer_pkg;

  localparam logic [7:0] DEFAULT_SOF_BYTE = 8'hA5;
  localparam int unsigned CLK_FREQ_HZ     = 100_000_000;
  localparam int unsigned UART_BAUD       = 9_600;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TYPE    = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHECK   = 2'd3
  } frame_state_t;

  // Running XOR checksum over the type and payload bytes.
  function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] data);
    return chk ^ data;
  endfunction

endpackage

// File: rtl/uart_msg_framer_gap_timer.sv
// Inter-byte gap timer: counts enabled cycles since the last clear and pulses
// expired when the count reaches TIMEOUT_CLKS-1.
module byte_gap_timer #(
  parameter int unsigned TIMEOUT_CLKS = 312_500
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CLKS - 1);

  logic [CNT_W-1:0] count_r;

  // A clear always wins over expiry, so a byte arriving on the last cycle is kept.
  assign expired = enable & ~clear & (count_r == LAST_CNT);

  // Gap counter; restarts after expiry so the pulse lasts one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear || expired) begin
      count_r <= {CNT_W{1'b0}};
    end else if (enable) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/uart_msg_framer.sv
// Frames the UART byte stream into SOF/type/payload/checksum price messages,
// reporting checksum and inter-byte timeout errors with a saturating counter.
module uart_msg_framer
  import uart_msg_framer_pkg::*;
#(
  parameter logic [7:0]  SOF_BYTE      = DEFAULT_SOF_BYTE,
  parameter int unsigned PAYLOAD_BYTES = 4,
  parameter int unsigned TIMEOUT_CLKS  = 312_500,
  parameter int unsigned ERR_CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  output logic                       msg_valid,
  output logic [7:0]                 msg_type,
  output logic [8*PAYLOAD_BYTES-1:0] msg_price,
  output logic                       busy,
  output logic                       err_chk,
  output logic                       err_timeout,
  output logic [ERR_CNT_W-1:0]       err_count
);

  localparam int unsigned PRICE_W = 8 * PAYLOAD_BYTES;
  localparam int unsigned IDX_W   = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);

  frame_state_t        state_r, next_state_s;
  logic                rx_valid_r;
  logic                byte_stb_s;
  logic [7:0]          type_r, type_nxt_s;
  logic [7:0]          chk_r, chk_nxt_s;
  logic [IDX_W-1:0]    idx_r, idx_nxt_s;
  logic [PRICE_W-1:0]  price_sh_r, price_nxt_s;
  logic                frame_ok_s;
  logic                frame_bad_s;
  logic                timeout_s;
  logic                gap_expired_s;
  logic                gap_clear_s;
  logic                gap_enable_s;

  assign byte_stb_s   = rx_valid & ~rx_valid_r;
  assign gap_clear_s  = byte_stb_s | (state_r == ST_IDLE);
  assign gap_enable_s = (state_r != ST_IDLE);

  byte_gap_timer #(
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) u_gap_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (gap_clear_s),
    .enable  (gap_enable_s),
    .expired (gap_expired_s)
  );

  // Next-state, datapath updates and frame outcome decode.
  always_comb begin
    next_state_s = state_r;
    type_nxt_s   = type_r;
    chk_nxt_s    = chk_r;
    idx_nxt_s    = idx_r;
    price_nxt_s  = price_sh_r;
    frame_ok_s   = 1'b0;
    frame_bad_s  = 1'b0;
    timeout_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (byte_stb_s && (rx_data == SOF_BYTE)) begin
          next_state_s = ST_TYPE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_TYPE: begin
        if (byte_stb_s) begin
          type_nxt_s   = rx_data;
          chk_nxt_s    = rx_data;
          idx_nxt_s    = {IDX_W{1'b0}};
          next_state_s = ST_PAYLOAD;
        end else begin
          next_state_s = ST_TYPE;
        end
      end
      ST_PAYLOAD: begin
        if (byte_stb_s) begin
          price_nxt_s      = price_sh_r << 8;
          price_nxt_s[7:0] = rx_data;
          chk_nxt_s        = chk_update(chk_r, rx_data);
          if (idx_r == LAST_IDX) begin
            next_state_s = ST_CHECK;
          end else begin
            idx_nxt_s = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
          end
        end else begin
          next_state_s = ST_PAYLOAD;
        end
      end
      ST_CHECK: begin
        if (byte_stb_s) begin
          if (rx_data == chk_r) begin
            frame_ok_s = 1'b1;
          end else begin
            frame_bad_s = 1'b1;
          end
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_CHECK;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase

    // The timer never expires on a strobe cycle, so this cannot override a byte.
    if (gap_expired_s) begin
      next_state_s = ST_IDLE;
      timeout_s    = 1'b1;
    end else begin
      timeout_s    = 1'b0;
    end
  end

  // State, datapath and registered output update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      rx_valid_r  <= 1'b0;
      type_r      <= 8'h00;
      chk_r       <= 8'h00;
      idx_r       <= {IDX_W{1'b0}};
      price_sh_r  <= {PRICE_W{1'b0}};
      msg_valid   <= 1'b0;
      msg_type    <= 8'h00;
      msg_price   <= {PRICE_W{1'b0}};
      busy        <= 1'b0;
      err_chk     <= 1'b0;
      err_timeout <= 1'b0;
      err_count   <= {ERR_CNT_W{1'b0}};
    end else begin
      state_r     <= next_state_s;
      rx_valid_r  <= rx_valid;
      type_r      <= type_nxt_s;
      chk_r       <= chk_nxt_s;
      idx_r       <= idx_nxt_s;
      price_sh_r  <= price_nxt_s;
      msg_valid   <= frame_ok_s;
      busy        <= (next_state_s != ST_IDLE);
      err_chk     <= frame_bad_s;
      err_timeout <= timeout_s;
      if (frame_ok_s) begin
        msg_type  <= type_r;
        msg_price <= price_sh_r;
      end else begin
        msg_type  <= msg_type;
        msg_price <= msg_price;
      end
      if ((frame_bad_s || timeout_s) && (err_count != {ERR_CNT_W{1'b1}})) begin
        err_count <= err_count + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      end else begin
        err_count <= err_count;
      end
    end
  end

endmodule
